adder_unit: RTL and testbench



---
 rtl/adder_unit.sv | 82 ++++++++
 tb/tb_adder_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/adder_unit.sv
// Registered two's-complement adder/subtractor (carry_in selects subtract), 1-cycle latency, no stall.
// Define ADDER_CLA_EN for a 4-bit carry-lookahead chain; the default build uses a ripple chain.
module adder_unit #(
  parameter int width = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] x,
  input  logic [width-1:0] y,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [width-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             out_valid
);

  logic [width-1:0] ye;
  logic [width-1:0] g;
  logic [width-1:0] p;
  logic [width-1:0] s;
  logic [width:0]   c;
  logic             ovf;
`ifdef ADDER_CLA_EN
  logic             gacc;
  logic             pacc;
`endif

  always_comb begin
    ye = y ^ {width{carry_in}};
    g  = x & ye;
    p  = x ^ ye;
    c  = '0;
    c[0] = carry_in;
`ifdef ADDER_CLA_EN
    gacc = 1'b0;
    pacc = 1'b1;
    // Each carry inside a group is a flat G/P term of the group carry-in;
    // only group carry-ins ripple from one group to the next.
    for (int base = 0; base < width; base += 4) begin
      for (int i = base; (i < base + 4) && (i < width); i++) begin
        gacc = 1'b0;
        pacc = 1'b1;
        for (int j = i; j >= base; j--) begin
          gacc = gacc | (pacc & g[j]);
          pacc = pacc & p[j];
        end
        c[i+1] = gacc | (pacc & c[base]);
      end
    end
`else
    for (int i = 0; i < width; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
`endif
    s   = p ^ c[width-1:0];
    ovf = (x[width-1] == ye[width-1]) && (s[width-1] != x[width-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= s;
        carry_out <= c[width];
        overflow  <= ovf;
        zero      <= (s == '0);
        negative  <= s[width-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_unit.sv
// Directed-table and random checks for adder_unit at width 9.
module tb_adder_unit;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] x, y;
  logic         carry_in, in_valid;
  logic [W-1:0] sum;
  logic         carry_out, overflow, zero, negative, out_valid;

  int checks = 0;
  int failures = 0;

  adder_unit #(.width(W)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .carry_in(carry_in),
    .in_valid(in_valid), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .negative(negative), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    logic         z;
    logic         n;
  } vec_t;

  vec_t tbl[11];

  // {out_valid, carry_out, overflow, zero, negative, sum}
  function automatic logic [13:0] outs();
    return {out_valid, carry_out, overflow, zero, negative, sum};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic vld);
    x = a; y = b; carry_in = cin; in_valid = vld;
  endtask

  // Independent reference: integer arithmetic with signed range check.
  function automatic logic [13:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin);
    int unsigned tot;
    int sa, sb, sr;
    logic [W-1:0] r;
    logic co, ov;
    sa = a[W-1] ? int'(a) - 512 : int'(a);
    sb = b[W-1] ? int'(b) - 512 : int'(b);
    if (cin) begin
      tot = int'(a) + ((~int'(b)) & 511) + 1;
      sr  = sa - sb;
    end else begin
      tot = int'(a) + int'(b);
      sr  = sa + sb;
    end
    r  = tot[W-1:0];
    co = tot[W];
    ov = (sr > 255) || (sr < -256);
    return {1'b1, co, ov, (r == 0), r[W-1], r};
  endfunction

  initial begin
    logic [13:0] exp;
    logic [W-1:0] a, b;
    logic cin;

    tbl[0]  = '{9'd5,   9'd3, 1'b0, 9'd8,   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{9'd5,   9'd3, 1'b1, 9'd2,   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{9'd127, 9'd1, 1'b0, 9'd128, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{9'd255, 9'd1, 1'b0, 9'd256, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{9'd127, 9'd1, 1'b1, 9'd126, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{9'd0,   9'd1, 1'b1, 9'd511, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{9'd3,   9'd3, 1'b1, 9'd0,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{9'd0,   9'd0, 1'b0, 9'd0,   1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{9'd0,   9'd0, 1'b1, 9'd0,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{9'd256, 9'd1, 1'b1, 9'd255, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{9'd511, 9'd1, 1'b0, 9'd0,   1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held with in_valid high: everything stays zero.
    rst_n = 1'b0;
    drive(9'd5, 9'd3, 1'b0, 1'b1);
    tick();
    tick();
    chk("reset_hold", outs(), 14'h0);

    // Back-to-back table vectors, one per cycle.
    rst_n = 1'b1;
    drive(tbl[0].x, tbl[0].y, tbl[0].cin, 1'b1);
    for (int i = 0; i < 11; i++) begin
      tick();
      exp = {1'b1, tbl[i].co, tbl[i].ov, tbl[i].z, tbl[i].n, tbl[i].sum};
      chk($sformatf("vec%0d", i), outs(), exp);
      if (i < 10) drive(tbl[i+1].x, tbl[i+1].y, tbl[i+1].cin, 1'b1);
    end

    // Valid gating: result held, out_valid drops.
    drive(9'd7, 9'd2, 1'b0, 1'b1);
    tick();
    chk("pre_hold", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd9});
    drive(9'd100, 9'd100, 1'b0, 1'b0);
    tick();
    chk("hold_idle", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd9});
    tick();
    chk("hold_idle2", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd9});

    // Reset mid-stream discards the in-flight operation.
    drive(9'd10, 9'd20, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("reset_mid", outs(), 14'h0);
    rst_n = 1'b1;
    drive(9'd10, 9'd20, 1'b0, 1'b0);
    tick();
    chk("post_reset_idle", outs(), 14'h0);
    drive(9'd10, 9'd20, 1'b1, 1'b1);
    tick();
    chk("first_after_reset", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'd502});

    // Random sweep against the integer model.
    a = 9'($urandom_range(0, 511));
    b = 9'($urandom_range(0, 511));
    cin = 1'($urandom_range(0, 1));
    drive(a, b, cin, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      exp = model(a, b, cin);
      tick();
      chk("random", outs(), exp);
      a = 9'($urandom_range(0, 511));
      b = 9'($urandom_range(0, 511));
      cin = 1'($urandom_range(0, 1));
      drive(a, b, cin, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
